// File: rtl/circ_dma_rq_arbiter_pkg.sv
// Shared widths and helpers for the circular TX DMA request arbiter.
// Packed per-channel fields are extracted through slice_field().
package circ_dma_pkg;

  localparam int DEF_RAM_ADDR_WIDTH = 18;
  localparam int DEF_DATA_BITS      = 3;
  localparam int DEF_BUS_ADDR_WIDTH = 32;

  localparam int LOC_W = DEF_RAM_ADDR_WIDTH - DEF_DATA_BITS + 1;
  localparam int BUS_W = DEF_BUS_ADDR_WIDTH - DEF_DATA_BITS;
  localparam int LEN_W = DEF_RAM_ADDR_WIDTH - DEF_DATA_BITS;

  localparam int PACK_MAX  = 512;
  localparam int FIELD_MAX = 64;

  // Channel index width, never narrower than one bit.
  function automatic int ch_bits_f(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  function automatic logic [FIELD_MAX-1:0] slice_field(input logic [PACK_MAX-1:0] vec,
                                                       input int idx, input int w);
    logic [PACK_MAX-1:0] sh;
    sh = vec >> (idx * w);
    return sh[FIELD_MAX-1:0] & ({FIELD_MAX{1'b1}} >> (FIELD_MAX - w));
  endfunction

endpackage

// File: rtl/circ_dma_rq_arbiter_if.sv
// Request/completion bundle between the TX engines, the arbiter and the DMA read requester.
// slave is the arbiter's view; master is the surrounding environment's view.
interface circ_dma_rq_arbiter_if
  import circ_dma_pkg::*;
#(
  parameter int CHANNELS  = 2,
  parameter int CH_BITS   = ch_bits_f(CHANNELS),
  parameter int LOC_WIDTH = LOC_W,
  parameter int BUS_WIDTH = BUS_W,
  parameter int LEN_WIDTH = LEN_W,
  parameter int TAG_BITS  = 11
);
  logic [CHANNELS-1:0]           s_ch_enable;
  logic [CHANNELS-1:0]           s_rq_valid;
  logic [CHANNELS-1:0]           s_rq_ready;
  logic [CHANNELS*LOC_WIDTH-1:0] s_rq_loc_addr;
  logic [CHANNELS*BUS_WIDTH-1:0] s_rq_bus_addr;
  logic [CHANNELS*LEN_WIDTH-1:0] s_rq_length;
  logic [CHANNELS*TAG_BITS-1:0]  s_rq_tag;
  logic                          m_rq_valid;
  logic                          m_rq_ready;
  logic [LOC_WIDTH-1:0]          m_rq_loc_addr;
  logic [BUS_WIDTH-1:0]          m_rq_bus_addr;
  logic [LEN_WIDTH-1:0]          m_rq_length;
  logic [CH_BITS+TAG_BITS-1:0]   m_rq_tag;
  logic                          m_rc_valid;
  logic                          m_rc_ready;
  logic [CH_BITS+TAG_BITS-1:0]   m_rc_tag;
  logic [CHANNELS-1:0]           s_rc_valid;
  logic [CHANNELS-1:0]           s_rc_ready;
  logic [TAG_BITS-1:0]           s_rc_tag;
  logic [CHANNELS*8-1:0]         stat_inflight;
  logic                          stat_cpl_err;

  modport slave (
    input  s_ch_enable, s_rq_valid, s_rq_loc_addr, s_rq_bus_addr, s_rq_length, s_rq_tag,
    input  m_rq_ready, m_rc_valid, m_rc_tag, s_rc_ready,
    output s_rq_ready, m_rq_valid, m_rq_loc_addr, m_rq_bus_addr, m_rq_length, m_rq_tag,
    output m_rc_ready, s_rc_valid, s_rc_tag, stat_inflight, stat_cpl_err
  );

  modport master (
    output s_ch_enable, s_rq_valid, s_rq_loc_addr, s_rq_bus_addr, s_rq_length, s_rq_tag,
    output m_rq_ready, m_rc_valid, m_rc_tag, s_rc_ready,
    input  s_rq_ready, m_rq_valid, m_rq_loc_addr, m_rq_bus_addr, m_rq_length, m_rq_tag,
    input  m_rc_ready, s_rc_valid, s_rc_tag, stat_inflight, stat_cpl_err
  );
endinterface

// File: rtl/circ_dma_rq_arbiter_rr_arbiter.sv
// Round-robin picker: grants the first requester at or after rr_ptr and moves the
// pointer past the winner whenever the grant is consumed.
module rr_arbiter #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic             advance,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx
);
  logic [IDX_W-1:0] r_rr_ptr;
  logic             w_any;

  always_comb begin : pick
    int  c;
    logic hit;
    grant     = '0;
    grant_idx = '0;
    w_any     = 1'b0;
    c         = 0;
    hit       = 1'b0;
    for (int k = 0; k < N; k++) begin
      c         = (int'(r_rr_ptr) + k) % N;
      hit       = !w_any && req[c];
      grant[c]  = hit;
      grant_idx = hit ? IDX_W'(c) : grant_idx;
      w_any     = w_any || hit;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr <= '0;
    end else if (advance && w_any) begin
      r_rr_ptr <= (grant_idx == IDX_W'(N - 1)) ? '0 : grant_idx + 1'b1;
    end
  end
endmodule

// File: rtl/circ_dma_rq_arbiter.sv
// Shares one DMA read requester between CHANNELS circular TX engines: round-robin grant
// into a single hold register, per-channel in-flight credits, completion routing by tag.
module circ_dma_rq_arbiter
  import circ_dma_pkg::*;
#(
  parameter int CHANNELS       = 2,
  parameter int CH_BITS        = ch_bits_f(CHANNELS),
  parameter int RAM_ADDR_WIDTH = DEF_RAM_ADDR_WIDTH,
  parameter int DATA_BITS      = DEF_DATA_BITS,
  parameter int BUS_ADDR_WIDTH = DEF_BUS_ADDR_WIDTH,
  parameter int TAG_BITS       = 11,
  parameter int MAX_INFLIGHT   = 8
) (
  input logic                  clk,
  input logic                  rst,
  circ_dma_rq_arbiter_if.slave bus
);
  localparam int W_LOC = RAM_ADDR_WIDTH - DATA_BITS + 1;
  localparam int W_BUS = BUS_ADDR_WIDTH - DATA_BITS;
  localparam int W_LEN = RAM_ADDR_WIDTH - DATA_BITS;
  localparam logic [7:0] MAX_CNT = 8'(MAX_INFLIGHT);

  logic                        r_valid;
  logic [W_LOC-1:0]            r_loc;
  logic [W_BUS-1:0]            r_bus;
  logic [W_LEN-1:0]            r_len;
  logic [CH_BITS+TAG_BITS-1:0] r_tag;
  logic [7:0]                  r_inflight [CHANNELS];
  logic                        r_cpl_err;

  logic [CHANNELS-1:0] w_elig, w_grant, w_inc, w_dec;
  logic [CH_BITS-1:0]  w_grant_idx, w_ch;
  logic                w_free, w_any, w_take, w_ch_ok, w_rc_hs, w_err;
  logic [W_LOC-1:0]    w_sel_loc;
  logic [W_BUS-1:0]    w_sel_bus;
  logic [W_LEN-1:0]    w_sel_len;
  logic [TAG_BITS-1:0] w_sel_tag;

  // The hold register is the only path from m_rq_ready back to s_rq_ready.
  assign w_free = !r_valid || bus.m_rq_ready;
  assign w_any  = |w_grant;
  assign w_take = w_free && w_any && !rst;

  always_comb begin
    w_elig = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      w_elig[i] = bus.s_rq_valid[i] && bus.s_ch_enable[i] && (r_inflight[i] < MAX_CNT);
    end
  end

  rr_arbiter #(.N(CHANNELS), .IDX_W(CH_BITS)) u_rr (
    .clk       (clk),
    .rst       (rst),
    .req       (w_elig),
    .advance   (w_free),
    .grant     (w_grant),
    .grant_idx (w_grant_idx)
  );

  assign bus.s_rq_ready = (w_free && !rst) ? w_grant : '0;

  assign w_sel_loc = W_LOC'(slice_field(PACK_MAX'(bus.s_rq_loc_addr), int'(w_grant_idx), W_LOC));
  assign w_sel_bus = W_BUS'(slice_field(PACK_MAX'(bus.s_rq_bus_addr), int'(w_grant_idx), W_BUS));
  assign w_sel_len = W_LEN'(slice_field(PACK_MAX'(bus.s_rq_length), int'(w_grant_idx), W_LEN));
  assign w_sel_tag = TAG_BITS'(slice_field(PACK_MAX'(bus.s_rq_tag), int'(w_grant_idx), TAG_BITS));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_loc   <= '0;
      r_bus   <= '0;
      r_len   <= '0;
      r_tag   <= '0;
    end else if (w_take) begin
      r_valid <= 1'b1;
      r_loc   <= w_sel_loc;
      r_bus   <= w_sel_bus;
      r_len   <= w_sel_len;
      r_tag   <= {w_grant_idx, w_sel_tag};
    end else if (bus.m_rq_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign bus.m_rq_valid    = r_valid;
  assign bus.m_rq_loc_addr = r_loc;
  assign bus.m_rq_bus_addr = r_bus;
  assign bus.m_rq_length   = r_len;
  assign bus.m_rq_tag      = r_tag;

  // Completions with an out-of-range channel are acknowledged here and dropped.
  assign w_ch     = bus.m_rc_tag[CH_BITS+TAG_BITS-1 -: CH_BITS];
  assign w_ch_ok  = int'(w_ch) < CHANNELS;
  assign w_rc_hs  = bus.m_rc_valid && bus.m_rc_ready;
  assign bus.s_rc_tag = bus.m_rc_tag[TAG_BITS-1:0];

  always_comb begin
    bus.s_rc_valid = '0;
    bus.m_rc_ready = 1'b1;
    for (int c = 0; c < CHANNELS; c++) begin
      bus.s_rc_valid[c] = bus.m_rc_valid && (int'(w_ch) == c);
      bus.m_rc_ready    = (int'(w_ch) == c) ? bus.s_rc_ready[c] : bus.m_rc_ready;
    end
  end

  always_comb begin
    w_inc = '0;
    w_dec = '0;
    w_err = w_rc_hs && !w_ch_ok;
    for (int i = 0; i < CHANNELS; i++) begin
      w_inc[i] = bus.s_rq_valid[i] && bus.s_rq_ready[i];
      w_dec[i] = w_rc_hs && (int'(w_ch) == i) && (r_inflight[i] != 8'd0);
      w_err    = w_err || (w_rc_hs && (int'(w_ch) == i) && (r_inflight[i] == 8'd0));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) r_inflight[i] <= 8'd0;
      r_cpl_err <= 1'b0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        case ({w_inc[i], w_dec[i]})
          2'b10:   r_inflight[i] <= r_inflight[i] + 8'd1;
          2'b01:   r_inflight[i] <= r_inflight[i] - 8'd1;
          default: r_inflight[i] <= r_inflight[i];
        endcase
      end
      r_cpl_err <= r_cpl_err || w_err;
    end
  end

  always_comb begin
    bus.stat_inflight = '0;
    for (int i = 0; i < CHANNELS; i++) bus.stat_inflight[i*8 +: 8] = r_inflight[i];
  end

  assign bus.stat_cpl_err = r_cpl_err;
endmodule

// File: tb/tb_circ_dma_rq_arbiter.sv
// Self-checking bench for circ_dma_rq_arbiter: directed scenarios plus a randomized run,
// all checked against a grant/credit model kept in the bench.
`timescale 1ns/1ps
module tb_circ_dma_rq_arbiter;
  import circ_dma_pkg::*;

  localparam int CH   = 2;
  localparam int CHB  = 1;
  localparam int TAGB = 11;
  localparam int MAXI = 8;
  localparam int LW   = LOC_W;
  localparam int BW   = BUS_W;
  localparam int NW   = LEN_W;
  localparam int MW   = CHB + TAGB;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  circ_dma_rq_arbiter_if #(.CHANNELS(CH), .CH_BITS(CHB), .LOC_WIDTH(LW), .BUS_WIDTH(BW),
                           .LEN_WIDTH(NW), .TAG_BITS(TAGB)) bus ();

  circ_dma_rq_arbiter #(.CHANNELS(CH), .CH_BITS(CHB), .RAM_ADDR_WIDTH(18), .DATA_BITS(3),
                        .BUS_ADDR_WIDTH(32), .TAG_BITS(TAGB), .MAX_INFLIGHT(MAXI)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Current request presented by each engine.
  logic [LW-1:0]   t_loc [CH];
  logic [BW-1:0]   t_bus [CH];
  logic [NW-1:0]   t_len [CH];
  logic [TAGB-1:0] t_tag [CH];

  // Reference model: credits, next channel in rotation, expected held request.
  int            mi [CH];
  int            mptr;
  bit            mh_valid;
  logic [LW-1:0] mh_loc;
  logic [BW-1:0] mh_bus;
  logic [NW-1:0] mh_len;
  logic [MW-1:0] mh_tag;
  bit            merr;

  task automatic new_fields(input int c);
    t_loc[c] = LW'($urandom);
    t_bus[c] = BW'($urandom);
    t_len[c] = NW'($urandom);
    t_tag[c] = TAGB'($urandom);
    bus.s_rq_loc_addr[c*LW +: LW]   = t_loc[c];
    bus.s_rq_bus_addr[c*BW +: BW]   = t_bus[c];
    bus.s_rq_length[c*NW +: NW]     = t_len[c];
    bus.s_rq_tag[c*TAGB +: TAGB]    = t_tag[c];
  endtask

  task automatic model_reset();
    for (int c = 0; c < CH; c++) mi[c] = 0;
    mptr = 0; mh_valid = 0; mh_loc = '0; mh_bus = '0; mh_len = '0; mh_tag = '0; merr = 0;
  endtask

  function automatic int model_grant();
    if (rst) return -1;
    if (mh_valid && !bus.m_rq_ready) return -1;
    for (int k = 0; k < CH; k++) begin
      int c;
      c = (mptr + k) % CH;
      if (bus.s_rq_valid[c] && bus.s_ch_enable[c] && mi[c] < MAXI) return c;
    end
    return -1;
  endfunction

  function automatic logic [CH-1:0] rdy_of(input int g);
    logic [CH-1:0] v;
    v = '0;
    if (g >= 0) v[g] = 1'b1;
    return v;
  endfunction

  // One clock: predict from the settled inputs, advance, update the model.
  task automatic tick(output int g);
    bit free, rc_hs;
    int rch;
    g     = model_grant();
    free  = !mh_valid || bus.m_rq_ready;
    rch   = int'(bus.m_rc_tag[MW-1 -: CHB]);
    rc_hs = bus.m_rc_valid && bus.s_rc_ready[rch];
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      if (rc_hs) begin
        if (mi[rch] > 0) mi[rch]--;
        else merr = 1'b1;
      end
      if (g >= 0) begin
        mi[g]++;
        mptr = (g + 1) % CH;
        mh_valid = 1'b1;
        mh_loc = t_loc[g]; mh_bus = t_bus[g]; mh_len = t_len[g];
        mh_tag = {CHB'(g), t_tag[g]};
      end else if (free) begin
        mh_valid = 1'b0;
      end
    end
    #1;
    if (g >= 0) new_fields(g);
  endtask

  task automatic idle_inputs();
    bus.s_ch_enable = '1; bus.s_rq_valid = '0; bus.m_rq_ready = 1'b1;
    bus.m_rc_valid = 1'b0; bus.m_rc_tag = '0; bus.s_rc_ready = '1;
  endtask

  task automatic do_reset();
    int g;
    idle_inputs();
    rst = 1'b1;
    #1; tick(g); tick(g);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    int g;
    rst = 1'b1;
    bus.s_ch_enable = '1; bus.s_rq_valid = '1; bus.m_rq_ready = 1'b1;
    bus.m_rc_valid = 1'b1; bus.m_rc_tag = {1'b1, 11'h155}; bus.s_rc_ready = 2'b10;
    #1; tick(g); tick(g); #1;
    total++; if (bus.s_rq_ready !== 2'b00) begin bad++; $display("FAIL rst_rq_ready: got %b want 00", bus.s_rq_ready); end
    total++; if (bus.m_rq_valid !== 1'b0) begin bad++; $display("FAIL rst_m_valid: got %b want 0", bus.m_rq_valid); end
    total++; if ({bus.m_rq_tag, bus.m_rq_loc_addr, bus.m_rq_bus_addr, bus.m_rq_length} !== '0) begin
      bad++; $display("FAIL rst_m_fields: got tag %h loc %h want 0", bus.m_rq_tag, bus.m_rq_loc_addr); end
    total++; if (bus.stat_inflight !== 16'h0000) begin bad++; $display("FAIL rst_inflight: got %h want 0000", bus.stat_inflight); end
    total++; if (bus.stat_cpl_err !== 1'b0) begin bad++; $display("FAIL rst_cpl_err: got %b want 0", bus.stat_cpl_err); end
    total++; if (bus.m_rc_ready !== 1'b1 || bus.s_rc_valid !== 2'b10 || bus.s_rc_tag !== 11'h155) begin
      bad++; $display("FAIL rst_rc_route: got rdy %b valid %b tag %h want 1 10 155", bus.m_rc_ready, bus.s_rc_valid, bus.s_rc_tag); end
    rst = 1'b0;
    idle_inputs();
    #1; tick(g);
    total++; if (bus.m_rq_valid !== 1'b0) begin bad++; $display("FAIL post_rst_valid: got %b want 0", bus.m_rq_valid); end
  endtask

  task automatic test_fairness();
    int g, grants;
    grants = 0;
    bus.s_ch_enable = 2'b11; bus.s_rq_valid = 2'b11; bus.m_rq_ready = 1'b1; bus.m_rc_valid = 1'b0;
    for (int cyc = 0; cyc < 22; cyc++) begin
      #1;
      total++; if (bus.s_rq_ready !== rdy_of(model_grant())) begin
        bad++; $display("FAIL fair_ready: cyc %0d got %b want %b", cyc, bus.s_rq_ready, rdy_of(model_grant())); end
      tick(g);
      if (bus.m_rq_valid) begin
        total++; if (int'(bus.m_rq_tag[MW-1]) != grants % 2 || bus.m_rq_tag !== mh_tag) begin
          bad++; $display("FAIL fair_order: grant %0d got tag %h want ch %0d tag %h", grants, bus.m_rq_tag, grants % 2, mh_tag); end
        grants++;
      end
    end
    total++; if (grants != 16) begin bad++; $display("FAIL fair_count: got %0d want 16", grants); end
    total++; if (bus.stat_inflight !== 16'h0808) begin bad++; $display("FAIL fair_inflight: got %h want 0808", bus.stat_inflight); end
    total++; if (bus.m_rq_valid !== 1'b0) begin bad++; $display("FAIL fair_stall: got %b want 0", bus.m_rq_valid); end
  endtask

  task automatic test_credit_release();
    int g, ch1, other;
    ch1 = 0; other = 0;
    bus.m_rc_valid = 1'b1; bus.m_rc_tag = {1'b1, 11'h005}; bus.s_rc_ready = 2'b11;
    #1;
    total++; if (bus.s_rc_valid !== 2'b10 || bus.s_rc_tag !== 11'h005 || bus.m_rc_ready !== 1'b1) begin
      bad++; $display("FAIL cr_route: got valid %b tag %h rdy %b want 10 005 1", bus.s_rc_valid, bus.s_rc_tag, bus.m_rc_ready); end
    tick(g);
    bus.m_rc_valid = 1'b0;
    total++; if (bus.stat_inflight !== 16'h0708) begin bad++; $display("FAIL cr_dec: got %h want 0708", bus.stat_inflight); end
    for (int cyc = 0; cyc < 4; cyc++) begin
      #1; tick(g);
      if (bus.m_rq_valid) begin
        if (bus.m_rq_tag[MW-1]) ch1++; else other++;
      end
    end
    total++; if (ch1 != 1 || other != 0) begin bad++; $display("FAIL cr_regrant: got ch1 %0d ch0 %0d want 1 0", ch1, other); end
    total++; if (bus.stat_inflight !== 16'h0808) begin bad++; $display("FAIL cr_final: got %h want 0808", bus.stat_inflight); end
  endtask

  task automatic test_backpressure();
    int g;
    logic [MW-1:0] first_tag, next_tag;
    do_reset();
    bus.s_rq_valid = 2'b01;
    first_tag = {1'b0, t_tag[0]};
    #1;
    total++; if (bus.s_rq_ready !== 2'b01) begin bad++; $display("FAIL bp_first: got %b want 01", bus.s_rq_ready); end
    tick(g);
    bus.m_rq_ready = 1'b0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      #1;
      total++; if (bus.s_rq_ready !== 2'b00) begin bad++; $display("FAIL bp_ready: cyc %0d got %b want 00", cyc, bus.s_rq_ready); end
      tick(g);
      total++; if (bus.m_rq_valid !== 1'b1 || bus.m_rq_tag !== first_tag ||
                   {bus.m_rq_loc_addr, bus.m_rq_bus_addr, bus.m_rq_length} !== {mh_loc, mh_bus, mh_len}) begin
        bad++; $display("FAIL bp_hold: cyc %0d got v %b tag %h want 1 %h", cyc, bus.m_rq_valid, bus.m_rq_tag, first_tag); end
    end
    bus.m_rq_ready = 1'b1;
    next_tag = {1'b0, t_tag[0]};
    #1;
    total++; if (bus.s_rq_ready !== 2'b01) begin bad++; $display("FAIL bp_release: got %b want 01", bus.s_rq_ready); end
    tick(g);
    total++; if (bus.m_rq_valid !== 1'b1 || bus.m_rq_tag !== next_tag) begin
      bad++; $display("FAIL bp_next: got v %b tag %h want 1 %h", bus.m_rq_valid, bus.m_rq_tag, next_tag); end
    bus.s_rq_valid = 2'b00;
    #1; tick(g);
  endtask

  task automatic test_simultaneous();
    int g;
    do_reset();
    bus.s_rq_valid = 2'b01;
    for (int cyc = 0; cyc < 3; cyc++) begin #1; tick(g); end
    bus.s_rq_valid = 2'b00;
    #1; tick(g);
    total++; if (bus.stat_inflight[7:0] !== 8'd3) begin bad++; $display("FAIL sim_pre: got %0d want 3", bus.stat_inflight[7:0]); end
    bus.s_rq_valid = 2'b01; bus.m_rc_valid = 1'b1; bus.m_rc_tag = {1'b0, 11'h03A}; bus.s_rc_ready = 2'b01;
    #1;
    total++; if (bus.s_rq_ready !== 2'b01 || bus.m_rc_ready !== 1'b1) begin
      bad++; $display("FAIL sim_hs: got rq %b rc %b want 01 1", bus.s_rq_ready, bus.m_rc_ready); end
    tick(g);
    bus.s_rq_valid = 2'b00; bus.m_rc_valid = 1'b0;
    total++; if (bus.stat_inflight[7:0] !== 8'd3 || bus.stat_cpl_err !== 1'b0) begin
      bad++; $display("FAIL sim_count: got %0d err %b want 3 0", bus.stat_inflight[7:0], bus.stat_cpl_err); end
  endtask

  task automatic test_error();
    int g;
    do_reset();
    bus.s_rq_valid = 2'b01;
    #1; tick(g);
    bus.s_rq_valid = 2'b00;
    bus.m_rc_valid = 1'b1; bus.m_rc_tag = {1'b1, 11'h2AA}; bus.s_rc_ready = 2'b11;
    #1; tick(g);
    bus.m_rc_valid = 1'b0;
    total++; if (bus.stat_cpl_err !== 1'b1) begin bad++; $display("FAIL err_set: got %b want 1", bus.stat_cpl_err); end
    total++; if (bus.stat_inflight !== 16'h0001) begin bad++; $display("FAIL err_counts: got %h want 0001", bus.stat_inflight); end
    #1; tick(g);
    total++; if (bus.stat_cpl_err !== 1'b1) begin bad++; $display("FAIL err_sticky: got %b want 1", bus.stat_cpl_err); end
    rst = 1'b1;
    #1; tick(g);
    rst = 1'b0;
    total++; if (bus.stat_cpl_err !== 1'b0 || bus.stat_inflight !== 16'h0000) begin
      bad++; $display("FAIL err_reset: got err %b counts %h want 0 0000", bus.stat_cpl_err, bus.stat_inflight); end
  endtask

  task automatic test_disable();
    int g;
    logic [MW-1:0] held;
    do_reset();
    bus.s_rq_valid = 2'b10; bus.m_rq_ready = 1'b0;
    held = {1'b1, t_tag[1]};
    #1;
    total++; if (bus.s_rq_ready !== 2'b10) begin bad++; $display("FAIL dis_load: got %b want 10", bus.s_rq_ready); end
    tick(g);
    bus.s_ch_enable = 2'b01; bus.s_rq_valid = 2'b11;
    for (int cyc = 0; cyc < 3; cyc++) begin
      #1; tick(g);
      total++; if (bus.m_rq_valid !== 1'b1 || bus.m_rq_tag !== held) begin
        bad++; $display("FAIL dis_held: got v %b tag %h want 1 %h", bus.m_rq_valid, bus.m_rq_tag, held); end
    end
    bus.m_rq_ready = 1'b1;
    for (int cyc = 0; cyc < 6; cyc++) begin
      #1;
      total++; if (bus.s_rq_ready !== 2'b01) begin bad++; $display("FAIL dis_ready: cyc %0d got %b want 01", cyc, bus.s_rq_ready); end
      tick(g);
    end
    total++; if (bus.stat_inflight !== 16'h0106) begin bad++; $display("FAIL dis_counts: got %h want 0106", bus.stat_inflight); end
    bus.s_ch_enable = 2'b11; bus.s_rq_valid = 2'b00;
  endtask

  task automatic test_random();
    int g, c;
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      bus.s_ch_enable = ($urandom_range(0, 5) == 0) ? CH'($urandom) : 2'b11;
      bus.s_rq_valid  = CH'($urandom);
      bus.m_rq_ready  = ($urandom_range(0, 3) != 0);
      c = $urandom_range(0, CH - 1);
      bus.m_rc_tag    = {CHB'(c), TAGB'($urandom)};
      bus.m_rc_valid  = (mi[c] > 0) && ($urandom_range(0, 2) == 0);
      bus.s_rc_ready  = CH'($urandom);
      #1;
      total++; if (bus.s_rq_ready !== rdy_of(model_grant()) || bus.m_rc_ready !== bus.s_rc_ready[c] ||
                   bus.s_rc_valid !== (bus.m_rc_valid ? rdy_of(c) : 2'b00) || bus.s_rc_tag !== bus.m_rc_tag[TAGB-1:0]) begin
        bad++; $display("FAIL rnd_comb: cyc %0d got rq %b rc %b/%b want rq %b ch %0d", cyc, bus.s_rq_ready,
                        bus.m_rc_ready, bus.s_rc_valid, rdy_of(model_grant()), c); end
      tick(g);
      total++; if (bus.m_rq_valid !== mh_valid || (mh_valid && {bus.m_rq_tag, bus.m_rq_loc_addr, bus.m_rq_bus_addr,
                   bus.m_rq_length} !== {mh_tag, mh_loc, mh_bus, mh_len})) begin
        bad++; $display("FAIL rnd_hold: cyc %0d got v %b tag %h want v %b tag %h", cyc, bus.m_rq_valid, bus.m_rq_tag, mh_valid, mh_tag); end
      total++; if (bus.stat_inflight !== {8'(mi[1]), 8'(mi[0])} || bus.stat_cpl_err !== merr) begin
        bad++; $display("FAIL rnd_stat: cyc %0d got %h err %b want %h err %b", cyc, bus.stat_inflight,
                        bus.stat_cpl_err, {8'(mi[1]), 8'(mi[0])}, merr); end
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    model_reset();
    for (int c = 0; c < CH; c++) new_fields(c);
    test_reset();
    test_fairness();
    test_credit_release();
    test_backpressure();
    test_simultaneous();
    test_error();
    test_disable();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/circ_dma_rq_arbiter.md
# circ_dma_rq_arbiter

Round-robin scheduler that shares one DMA-buffer request/completion port (`m_rq_*` / `m_rc_*`) between `CHANNELS` circular TX DMA engines. It sits between the per-channel TX engines and the single PCIe DMA read requester. Each channel's request tag is extended with the channel index, and completions are routed back by that index. A per-channel in-flight credit counter keeps any one channel from monopolising the requester.

## Interface

**Parameters**
- `CHANNELS`, default 2: number of requesting TX engines, 2..8.
- `CH_BITS`, default `$clog2(CHANNELS)`: width of the channel index (minimum 1).
- `RAM_ADDR_WIDTH`, default 18: local RAM address width.
- `DATA_BITS`, default 3: log2 of the bus word size in bytes.
- `BUS_ADDR_WIDTH`, default 32: host bus address width.
- `TAG_BITS`, default 11: per-channel tag width (`USER_BUF_BITS` + `BURSTS_BITS`).
- `MAX_INFLIGHT`, default 8: issued but uncompleted requests allowed per channel, 1..255.

**Ports**
- `clk`, in, 1: clock.
- `rst`, in, 1: synchronous, active-high reset.
- `s_ch_enable`, in, `CHANNELS`: per-channel grant enable.
- `s_rq_valid`, in, `CHANNELS`: request valid, one bit per channel.
- `s_rq_ready`, out, `CHANNELS`: request accept, one bit per channel.
- `s_rq_loc_addr`, in, `CHANNELS*(RAM_ADDR_WIDTH-DATA_BITS+1)`: packed local addresses. Channel i occupies slice i.
- `s_rq_bus_addr`, in, `CHANNELS*(BUS_ADDR_WIDTH-DATA_BITS)`: packed bus word addresses.
- `s_rq_length`, in, `CHANNELS*(RAM_ADDR_WIDTH-DATA_BITS)`: packed lengths, in words minus 1.
- `s_rq_tag`, in, `CHANNELS*TAG_BITS`: packed tags.
- `m_rq_valid`, out, 1: merged request valid.
- `m_rq_ready`, in, 1: merged request ready.
- `m_rq_loc_addr`, out, `RAM_ADDR_WIDTH-DATA_BITS+1`: merged local address.
- `m_rq_bus_addr`, out, `BUS_ADDR_WIDTH-DATA_BITS`: merged bus address.
- `m_rq_length`, out, `RAM_ADDR_WIDTH-DATA_BITS`: merged length.
- `m_rq_tag`, out, `CH_BITS+TAG_BITS`: `{channel, tag}`.
- `m_rc_valid`, in, 1: completion valid.
- `m_rc_ready`, out, 1: completion ready.
- `m_rc_tag`, in, `CH_BITS+TAG_BITS`: completion tag, `{channel, tag}`.
- `s_rc_valid`, out, `CHANNELS`: per-channel completion valid.
- `s_rc_ready`, in, `CHANNELS`: per-channel completion ready.
- `s_rc_tag`, out, `TAG_BITS`: completion tag with the channel field stripped. Shared by all channels.
- `stat_inflight`, out, `CHANNELS*8`: per-channel in-flight counts.
- `stat_cpl_err`, out, 1: sticky error flag for a completion that hit a channel with zero requests in flight, or a channel index ≥ `CHANNELS`.

## Operation

- **Output register.** A single output register, `hold`, carries `m_rq_*`.
  - `hold` is free when `!m_rq_valid || m_rq_ready`.
- **Eligibility.** Channel i is eligible when all three hold:
  - `s_rq_valid[i]`,
  - `s_ch_enable[i]`,
  - `inflight[i] < MAX_INFLIGHT`.
- **Grant.** When `hold` is free and at least one channel is eligible:
  - Grant the first eligible channel at or after `rr_ptr`, wrapping modulo `CHANNELS`.
  - Assert `s_rq_ready[g]` in that same cycle. At most one ready bit is high per cycle.
  - Load `hold` with that channel's fields. `m_rq_tag` becomes `{g, tag}`.
  - Set `rr_ptr` to `g+1` modulo `CHANNELS`.
- **Idle.** When no channel is eligible, `rr_ptr` is unchanged. `m_rq_valid` clears on the `m_rq_ready` handshake.
- **In-flight counters.**
  - `inflight[g]` increments on the `s_rq_valid[g] && s_rq_ready[g]` handshake.
  - It decrements on the completion handshake for channel `m_rc_tag[top CH_BITS]`.
  - If both events hit the same channel in the same cycle, the count is unchanged.
- **Completion routing.** Purely combinational:
  - `s_rc_valid[c] = m_rc_valid && (c == ch)`.
  - `m_rc_ready = s_rc_ready[ch]`.
  - `s_rc_tag = m_rc_tag[TAG_BITS-1:0]`.
- **Invalid completions.** If `ch ≥ CHANNELS`:
  - `m_rc_ready` = 1, so the completion is dropped.
  - `stat_cpl_err` is set.
  - No counter changes.
- **Underflow.** A completion to a channel whose `inflight` is 0 sets `stat_cpl_err`. The counter stays at 0.
- **Disable.** Deasserting `s_ch_enable[i]` blocks new grants to channel i only. A request already in `hold` still completes its handshake, and completions for channel i are still routed.
- **No combinational requester path.** `m_rq_ready` never reaches `s_rq_ready` combinationally except through the `hold`-free term.

## Timing

- **Reset values:**
  - `m_rq_valid` = 0, `s_rq_ready` = 0.
  - `m_rq_*` data fields = 0.
  - `rr_ptr` = 0, all `inflight` = 0, `stat_cpl_err` = 0.
  - `m_rc_ready` and `s_rc_valid` follow their combinational rules.
- **Latency.** `m_rq_valid` asserts the cycle after the request is accepted.
- **Throughput.** One request per cycle while `m_rq_ready` stays high, so back-to-back grants are supported.
- **Fairness.** With N channels continuously eligible, each channel is granted exactly once every N grants.
- **Reset mid-operation.**
  - A request sitting in `hold` is discarded.
  - Completions arriving after reset still route, but underflow sets `stat_cpl_err`.
  - Software must quiesce the channels before resetting.

## Structure

- **Shared package `circ_dma_pkg`:**
  - field-width localparams `LOC_W`, `BUS_W`, `LEN_W`;
  - `CH_BITS` computation;
  - slice helper functions that extract channel i's fields from the packed vectors.
- **Sub-module `rr_arbiter`:**
  - parameter `N`;
  - inputs `req[N]`, `advance`;
  - outputs one-hot `grant[N]` and `grant_idx`;
  - owns `rr_ptr`.
- **Top level** owns the `hold` register, the counters and completion routing.

## Test plan

1. **Fairness.** `CHANNELS`=2, both channels valid permanently, `m_rq_ready`=1, no completions, `MAX_INFLIGHT`=8 → grants alternate 0,1,0,1,… After 16 grants, both `inflight` = 8 and no further grants occur.
2. **Credit release.** Continue scenario 1 and return one completion with tag `{1,0x05}` → `s_rc_valid` = 2'b10 and `s_rc_tag` = 0x05. `inflight[1]` drops to 7, and exactly one more grant goes to channel 1.
3. **Backpressure.** `m_rq_ready`=0 for 5 cycles with channel 0 valid → `m_rq_*` stays stable and `s_rq_ready` stays 0 after the first accept. On release, the next request is issued on the following cycle.
4. **Simultaneous events.** Channel 0 at `inflight`=3 issues and completes in the same cycle → count stays 3.
5. **Error paths.** Completion `{1,x}` while `inflight[1]`=0 → `stat_cpl_err`=1 and the counter stays 0. Then assert `rst` → `stat_cpl_err`=0 and all counts = 0.
6. **Disable.** `s_ch_enable`=2'b01 with both channels valid → only channel 0 is granted. Channel 1's held request is not dropped.
